// File: rtl/usb_hid_pkg.sv
// Shared types and report layout for the HID boot-keyboard event decoder.
package usb_hid_pkg;

    localparam int NUM_KEYS = 6;
    localparam int MOD_MSB  = 63;
    localparam int RSV_MSB  = 55;
    localparam int KEY0_MSB = 47;

    localparam logic [7:0] KEY_NONE     = 8'h00;
    localparam logic [7:0] KEY_ROLLOVER = 8'h01;

    typedef struct packed {
        logic       press;
        logic [7:0] code;
    } kbd_evt_t;

    typedef enum logic [1:0] {IDLE, BRK, MK, COMMIT} scan_state_e;

    typedef logic [NUM_KEYS-1:0][7:0] key_arr_t;

    // Element i holds keycode k<i>; k0 is the most significant key byte.
    function automatic key_arr_t get_keys(input logic [63:0] rpt);
        key_arr_t k;
        for (int i = 0; i < NUM_KEYS; i++) k[i] = rpt[KEY0_MSB-8*i -: 8];
        return k;
    endfunction

endpackage

// File: rtl/usb_evt_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module usb_evt_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    T           mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        do_push, do_pop;

    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
        data_o  = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/usb_hid_kbd_event_decoder.sv
// Diffs successive HID boot-keyboard reports and emits press/release events,
// all releases of a report before any of its presses.
module usb_hid_kbd_event_decoder
    import usb_hid_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter bit FILTER_ROLLOVER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] report_i,
    input  logic        report_valid_i,
    input  logic        clear_i,
    output logic        evt_valid_o,
    input  logic        evt_ready_i,
    output logic [7:0]  evt_code_o,
    output logic        evt_press_o,
    output logic [7:0]  mod_o,
    output logic        busy_o,
    output logic [7:0]  drop_cnt_o
);
    scan_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic        pend_full_q, pend_full_d;
    logic [7:0]  pend_mod_q, pend_mod_d;
    key_arr_t    pend_keys_q, pend_keys_d;
    logic [7:0]  cur_mod_q, cur_mod_d;
    key_arr_t    cur_keys_q, cur_keys_d;
    key_arr_t    prev_keys_q, prev_keys_d;
    logic [7:0]  mod_q, mod_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        cap, consume, is_roll;
    logic [7:0]  in_mod;
    key_arr_t    in_keys;
    logic [7:0]  scan_code;
    key_arr_t    other_keys, self_keys;
    logic        hit, need, push, fifo_full, fifo_empty, pop;
    kbd_evt_t    push_evt, head_evt;
    logic        unused_rsv;

    assign unused_rsv = ^report_i[RSV_MSB -: 8];

    // Capture and one-deep pending slot.
    always_comb begin
        valid_d = report_valid_i;
        in_mod  = clear_i ? 8'h00 : report_i[MOD_MSB -: 8];
        in_keys = clear_i ? '0 : get_keys(report_i);
        is_roll = FILTER_ROLLOVER && !clear_i;
        for (int i = 0; i < NUM_KEYS; i++)
            if (in_keys[i] != KEY_ROLLOVER) is_roll = 1'b0;
        cap     = (clear_i || (report_valid_i && !valid_q)) && !is_roll;
        consume = (state_q == IDLE) && pend_full_q;

        pend_full_d = pend_full_q;
        pend_mod_d  = pend_mod_q;
        pend_keys_d = pend_keys_q;
        drop_cnt_d  = drop_cnt_q;
        if (cap) begin
            pend_full_d = 1'b1;
            pend_mod_d  = in_mod;
            pend_keys_d = in_keys;
            if (pend_full_q && !consume && drop_cnt_q != 8'hFF)
                drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (consume) begin
            pend_full_d = 1'b0;
        end
    end

    // Scan FSM: BRK walks prev looking for released keys, MK walks cur for new ones.
    always_comb begin
        other_keys = (state_q == BRK) ? cur_keys_q  : prev_keys_q;
        self_keys  = (state_q == BRK) ? prev_keys_q : cur_keys_q;
        scan_code  = self_keys[idx_q];
        hit = 1'b0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            if (other_keys[j] == scan_code) hit = 1'b1;
            if (3'(j) < idx_q && self_keys[j] == scan_code) hit = 1'b1;
        end
        need     = (state_q == BRK || state_q == MK) && scan_code != KEY_NONE && !hit;
        push     = need && !fifo_full;
        push_evt = '{press: (state_q == MK), code: scan_code};

        state_d     = state_q;
        idx_d       = idx_q;
        cur_mod_d   = cur_mod_q;
        cur_keys_d  = cur_keys_q;
        prev_keys_d = prev_keys_q;
        mod_d       = mod_q;
        case (state_q)
            IDLE: if (pend_full_q) begin
                cur_mod_d  = pend_mod_q;
                cur_keys_d = pend_keys_q;
                idx_d      = 3'd0;
                state_d    = BRK;
            end
            BRK, MK: if (!(need && fifo_full)) begin
                if (idx_q == 3'd5) begin
                    idx_d   = 3'd0;
                    state_d = (state_q == BRK) ? MK : COMMIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            COMMIT: begin
                prev_keys_d = cur_keys_q;
                mod_d       = cur_mod_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            pend_full_q <= 1'b0;
            pend_mod_q  <= '0;
            pend_keys_q <= '0;
            cur_mod_q   <= '0;
            cur_keys_q  <= '0;
            prev_keys_q <= '0;
            mod_q       <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            pend_full_q <= pend_full_d;
            pend_mod_q  <= pend_mod_d;
            pend_keys_q <= pend_keys_d;
            cur_mod_q   <= cur_mod_d;
            cur_keys_q  <= cur_keys_d;
            prev_keys_q <= prev_keys_d;
            mod_q       <= mod_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign pop = evt_valid_o && evt_ready_i;

    usb_evt_fifo #(.DEPTH(FIFO_DEPTH), .T(kbd_evt_t)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_evt),
        .pop_i   (pop),
        .data_o  (head_evt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign evt_valid_o = !fifo_empty;
    assign evt_code_o  = head_evt.code;
    assign evt_press_o = head_evt.press;
    assign mod_o       = mod_q;
    assign busy_o      = (state_q != IDLE) || pend_full_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_usb_hid_kbd_event_decoder.sv
// Scoreboard bench: a reference diff model queues expected events, a negedge monitor checks each handshake.
module tb_usb_hid_kbd_event_decoder;
    import usb_hid_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] report_i = '0;
    logic        report_valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        evt_valid_o;
    logic        evt_ready_i = 1'b1;
    logic [7:0]  evt_code_o;
    logic        evt_press_o;
    logic [7:0]  mod_o;
    logic        busy_o;
    logic [7:0]  drop_cnt_o;

    int          checks = 0;
    int          errors = 0;
    int          evt_seen = 0;
    kbd_evt_t    exp_q[$];
    kbd_evt_t    mon_e;
    logic [7:0]  m_prev [6];
    logic [7:0]  m_mod = 8'h00;

    usb_hid_kbd_event_decoder #(.FIFO_DEPTH(4), .FILTER_ROLLOVER(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .report_i       (report_i),
        .report_valid_i (report_valid_i),
        .clear_i        (clear_i),
        .evt_valid_o    (evt_valid_o),
        .evt_ready_i    (evt_ready_i),
        .evt_code_o     (evt_code_o),
        .evt_press_o    (evt_press_o),
        .mod_o          (mod_o),
        .busy_o         (busy_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!rst && evt_valid_o && evt_ready_i) begin
            checks++;
            evt_seen++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got press=%0b code=%02h, required no event", evt_press_o, evt_code_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({evt_press_o, evt_code_o} !== {mon_e.press, mon_e.code}) begin
                    errors++;
                    $display("FAIL evt_order: got press=%0b code=%02h, required press=%0b code=%02h",
                             evt_press_o, evt_code_o, mon_e.press, mon_e.code);
                end
            end
        end
    end

    // Reference model: releases of vanished keys, then presses of new keys, duplicates ignored.
    task automatic expect_report(input logic [63:0] r);
        logic [7:0] nk [6];
        bit roll = 1'b1;
        bit found, dup;
        for (int i = 0; i < 6; i++) begin
            nk[i] = r[47-8*i -: 8];
            if (nk[i] != 8'h01) roll = 1'b0;
        end
        if (roll) return;
        for (int i = 0; i < 6; i++) begin
            found = 1'b0; dup = 1'b0;
            for (int j = 0; j < 6; j++) if (nk[j] == m_prev[i]) found = 1'b1;
            for (int j = 0; j < i; j++) if (m_prev[j] == m_prev[i]) dup = 1'b1;
            if (m_prev[i] != 8'h00 && !found && !dup) exp_q.push_back('{press: 1'b0, code: m_prev[i]});
        end
        for (int i = 0; i < 6; i++) begin
            found = 1'b0; dup = 1'b0;
            for (int j = 0; j < 6; j++) if (m_prev[j] == nk[i]) found = 1'b1;
            for (int j = 0; j < i; j++) if (nk[j] == nk[i]) dup = 1'b1;
            if (nk[i] != 8'h00 && !found && !dup) exp_q.push_back('{press: 1'b1, code: nk[i]});
        end
        for (int i = 0; i < 6; i++) m_prev[i] = nk[i];
        m_mod = r[63:56];
    endtask

    task automatic send(input logic [63:0] r);
        @(posedge clk); #1;
        report_i = r;
        report_valid_i = 1'b1;
        @(posedge clk); #1;
        report_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((busy_o || evt_valid_o) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: busy=%0b evt_valid=%0b after %0d cycles, required idle", name, busy_o, evt_valid_o, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) m_prev[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({evt_valid_o, evt_code_o, evt_press_o, mod_o, busy_o, drop_cnt_o} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b code=%02h press=%0b mod=%02h busy=%0b drop=%0d, required all 0",
                     evt_valid_o, evt_code_o, evt_press_o, mod_o, busy_o, drop_cnt_o);
        end
    endtask

    task automatic test_first_press();
        int n = 0;
        expect_report(64'h02_00_04_00_00_00_00_00);
        send(64'h02_00_04_00_00_00_00_00);
        @(negedge clk);
        while (busy_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 14) begin
            errors++;
            $display("FAIL busy_latency: got %0d busy cycles after capture, required 14", n);
        end
        wait_done("first_press");
        checks++;
        if (mod_o !== 8'h02) begin
            errors++;
            $display("FAIL first_mod: got %02h, required 02", mod_o);
        end
    endtask

    task automatic test_change_key();
        expect_report(64'h00_00_05_00_00_00_00_00);
        send(64'h00_00_05_00_00_00_00_00);
        wait_done("change_key");
        checks++;
        if (mod_o !== m_mod) begin
            errors++;
            $display("FAIL change_mod: got %02h, required %02h", mod_o, m_mod);
        end
    endtask

    task automatic test_held_level();
        int seen0 = evt_seen;
        @(posedge clk); #1;
        report_i = 64'h00_00_05_06_00_00_00_00;
        report_valid_i = 1'b1;
        expect_report(report_i);
        repeat (50) @(posedge clk);
        #1 report_valid_i = 1'b0;
        wait_done("held_level");
        checks++;
        if (evt_seen - seen0 != 1 || drop_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL held_level: got %0d events drop=%0d, required 1 event drop=0", evt_seen - seen0, drop_cnt_o);
        end
    endtask

    task automatic test_dup_and_rollover();
        int seen0;
        expect_report(64'h00_00_1E_1E_00_00_00_00);
        send(64'h00_00_1E_1E_00_00_00_00);
        wait_done("dup_keys");
        seen0 = evt_seen;
        expect_report(64'h55_00_01_01_01_01_01_01);
        send(64'h55_00_01_01_01_01_01_01);
        repeat (20) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || evt_seen != seen0 || mod_o !== m_mod || drop_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL rollover_filter: got busy=%0b events=%0d mod=%02h drop=%0d, required busy=0 events=0 mod=%02h drop=0",
                     busy_o, evt_seen - seen0, mod_o, drop_cnt_o, m_mod);
        end
    endtask

    task automatic test_stall();
        logic [7:0] code0;
        expect_report(64'h0);
        send(64'h0);
        wait_done("stall_prep");
        evt_ready_i = 1'b0;
        expect_report(64'h00_00_04_05_06_07_08_09);
        send(64'h00_00_04_05_06_07_08_09);
        repeat (40) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || evt_valid_o !== 1'b1 || evt_code_o !== 8'h04 || evt_press_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_head: got busy=%0b valid=%0b code=%02h press=%0b, required busy=1 valid=1 code=04 press=1",
                     busy_o, evt_valid_o, evt_code_o, evt_press_o);
        end
        code0 = evt_code_o;
        repeat (5) @(negedge clk);
        checks++;
        if (evt_code_o !== code0 || evt_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got code=%02h valid=%0b, required code=%02h valid=1", evt_code_o, evt_valid_o, code0);
        end
        @(posedge clk); #1 evt_ready_i = 1'b1;
        wait_done("stall_drain");
    endtask

    task automatic test_back_to_back();
        expect_report(64'h00_00_04_00_00_00_00_00);
        send(64'h00_00_04_00_00_00_00_00);
        send(64'h00_00_10_11_00_00_00_00);
        send(64'h11_00_04_05_00_00_00_00);
        expect_report(64'h11_00_04_05_00_00_00_00);
        wait_done("back_to_back");
        checks++;
        if (drop_cnt_o !== 8'd1 || mod_o !== 8'h11) begin
            errors++;
            $display("FAIL drop_count: got drop=%0d mod=%02h, required drop=1 mod=11", drop_cnt_o, mod_o);
        end
    endtask

    task automatic test_clear();
        @(posedge clk); #1;
        clear_i = 1'b1;
        report_valid_i = 1'b1;
        report_i = 64'h00_00_07_00_00_00_00_00;
        expect_report(64'h0);
        @(posedge clk); #1 clear_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 report_valid_i = 1'b0;
        wait_done("clear");
        checks++;
        if (mod_o !== 8'h00) begin
            errors++;
            $display("FAIL clear_mod: got %02h, required 00", mod_o);
        end
    endtask

    task automatic test_reset_mid_scan();
        expect_report(64'h00_00_20_00_00_00_00_00);
        send(64'h00_00_20_00_00_00_00_00);
        wait_done("mid_prep");
        evt_ready_i = 1'b0;
        send(64'h00_00_21_00_00_00_00_00);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) m_prev[i] = 8'h00;
        m_mod = 8'h00;
        evt_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (evt_valid_o !== 1'b0 || busy_o !== 1'b0 || mod_o !== 8'h00 || drop_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%0b busy=%0b mod=%02h drop=%0d, required all 0",
                     evt_valid_o, busy_o, mod_o, drop_cnt_o);
        end
        expect_report(64'h00_00_20_00_00_00_00_00);
        send(64'h00_00_20_00_00_00_00_00);
        wait_done("mid_after");
    endtask

    initial begin
        test_reset();
        test_first_press();
        test_change_key();
        test_held_level();
        test_dup_and_rollover();
        test_stall();
        test_back_to_back();
        test_clear();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
